// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Writeback encodings mirror the decoder's wb_sel field.
package pipe_ctrl_pkg;

  localparam logic [1:0]  WB_ALU    = 2'b00;
  localparam logic [1:0]  WB_LSU    = 2'b01;
  localparam logic [1:0]  WB_PC4    = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  // One bundle of pipeline-register controls; flush_n_* are active-low clears.
  typedef struct packed {
    logic enable_pc;
    logic enable_if;
    logic enable_id;
    logic enable_ex;
    logic flush_n_if;
    logic flush_n_id;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam hz_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[24:20];
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: EX holds a load whose rd feeds a source register of the ID instruction.
// rs2 is compared for every format, which may add a harmless bubble for I-type consumers.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] i_instr_id,
  input  logic [31:0] i_instr_ex,
  input  logic        i_rd_wren_ex,
  input  logic [1:0]  i_wb_sel_ex,
  output logic        o_load_use
);

  logic [4:0] rd_ex;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       is_load_ex;
  logic       unused_bits;

  assign rd_ex       = rd_of(i_instr_ex);
  assign rs1_id      = rs1_of(i_instr_id);
  assign rs2_id      = rs2_of(i_instr_id);
  assign is_load_ex  = i_rd_wren_ex && (i_wb_sel_ex == WB_LSU);
  assign unused_bits = ^{i_instr_id[31:25], i_instr_id[14:0],
                         i_instr_ex[31:12], i_instr_ex[6:0]};

  assign o_load_use = is_load_ex && (rd_ex != 5'd0) &&
                      ((rd_ex == rs1_id) || (rd_ex == rs2_id));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: LSU freeze, redirect flush, load-use bubble,
// saturating stall/flush counters and a sticky LSU-timeout flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_instr_id,
  input  logic [31:0]      i_instr_ex,
  input  logic             i_rd_wren_ex,
  input  logic [1:0]       i_wb_sel_ex,
  input  logic             i_pc_sel_ex,
  input  logic             i_mem_req_mem,
  input  logic             i_lsu_ready,
  output logic             o_enable_pc,
  output logic             o_enable_if,
  output logic             o_enable_id,
  output logic             o_enable_ex,
  output logic             o_flush_n_if,
  output logic             o_flush_n_id,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic             o_timeout,
  output hz_state_e        o_state
);

  localparam int WAIT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC);

  hz_state_e         state_q, state_d;
  hz_ctrl_t          ctrl;
  logic              load_use;
  logic              mem_freeze;
  logic              stall_inc;
  logic              flush_inc;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout_q;

  hazard_detect u_hazard_detect (
    .i_instr_id   (i_instr_id),
    .i_instr_ex   (i_instr_ex),
    .i_rd_wren_ex (i_rd_wren_ex),
    .i_wb_sel_ex  (i_wb_sel_ex),
    .o_load_use   (load_use)
  );

  assign mem_freeze = i_mem_req_mem && !i_lsu_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Leaving MEM_WAIT needs no extra cycle: the release cycle is decoded like RUN.
  always_comb begin
    state_d   = state_q;
    ctrl      = CTRL_RUN;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      RUN:      if (mem_freeze)  state_d = MEM_WAIT;
      MEM_WAIT: if (!mem_freeze) state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (i_rst) begin
      ctrl = CTRL_RESET;
    end else if (mem_freeze) begin
      ctrl.enable_pc = 1'b0;
      ctrl.enable_if = 1'b0;
      ctrl.enable_id = 1'b0;
      ctrl.enable_ex = 1'b0;
      stall_inc      = 1'b1;
    end else if (i_pc_sel_ex) begin
      ctrl.flush_n_if = 1'b0;
      ctrl.flush_n_id = 1'b0;
      flush_inc       = 1'b1;
    end else if (load_use) begin
      ctrl.enable_pc  = 1'b0;
      ctrl.enable_if  = 1'b0;
      ctrl.flush_n_id = 1'b0;
      stall_inc       = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  // Every frozen cycle counts, including the RUN cycle that enters MEM_WAIT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (mem_freeze) begin
      if (wait_cnt_q != WAIT_MAX)            wait_cnt_q <= wait_cnt_q + 1'b1;
      if (wait_cnt_q == (WAIT_MAX - 1'b1))   timeout_q  <= 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign o_enable_pc  = ctrl.enable_pc;
  assign o_enable_if  = ctrl.enable_if;
  assign o_enable_id  = ctrl.enable_id;
  assign o_enable_ex  = ctrl.enable_ex;
  assign o_flush_n_if = ctrl.flush_n_if;
  assign o_flush_n_id = ctrl.flush_n_id;
  assign o_stall_cnt  = stall_cnt_q;
  assign o_flush_cnt  = flush_cnt_q;
  assign o_timeout    = timeout_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table plus hand sequences for
// timeout, reset-mid-wait and counter saturation.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [31:0] I_NOP  = 32'h0000_0013;
  localparam logic [31:0] I_LW5  = 32'h0000_A283;
  localparam logic [31:0] I_LW0  = 32'h0000_2003;
  localparam logic [31:0] I_ADD  = 32'h0072_8333; // add x6,x5,x7
  localparam logic [31:0] I_ADD2 = 32'h0053_8333; // add x6,x7,x5
  localparam logic [31:0] I_Z    = 32'h0000_0033; // add x0,x0,x0

  localparam logic [5:0] C_IDLE  = 6'b111111;
  localparam logic [5:0] C_RST   = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b001110;
  localparam logic [5:0] C_REDIR = 6'b111100;
  localparam logic [5:0] C_FRZ   = 6'b000011;

  typedef struct {
    logic        rst;
    logic [31:0] id;
    logic [31:0] ex;
    logic        wren;
    logic [1:0]  wb;
    logic        pc_sel;
    logic        mem_req;
    logic        ready;
    logic [5:0]  exp_ctrl;
    logic [3:0]  exp_stall;
    logic [3:0]  exp_flush;
    logic        exp_to;
    hz_state_e   exp_state;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr_id;
  logic [31:0] instr_ex;
  logic        rd_wren_ex;
  logic [1:0]  wb_sel_ex;
  logic        pc_sel_ex;
  logic        mem_req_mem;
  logic        lsu_ready;
  logic        enable_pc, enable_if, enable_id, enable_ex;
  logic        flush_n_if, flush_n_id;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;
  logic        timeout;
  hz_state_e   state;
  logic [5:0]  ctrl;

  int checks = 0;
  int errors = 0;
  vec_t vecs[21];

  assign ctrl = {enable_pc, enable_if, enable_id, enable_ex, flush_n_if, flush_n_id};

  pipe_hazard_ctrl #(.CNT_W(4), .TIMEOUT_CYC(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_instr_id    (instr_id),
    .i_instr_ex    (instr_ex),
    .i_rd_wren_ex  (rd_wren_ex),
    .i_wb_sel_ex   (wb_sel_ex),
    .i_pc_sel_ex   (pc_sel_ex),
    .i_mem_req_mem (mem_req_mem),
    .i_lsu_ready   (lsu_ready),
    .o_enable_pc   (enable_pc),
    .o_enable_if   (enable_if),
    .o_enable_id   (enable_id),
    .o_enable_ex   (enable_ex),
    .o_flush_n_if  (flush_n_if),
    .o_flush_n_id  (flush_n_id),
    .o_stall_cnt   (stall_cnt),
    .o_flush_cnt   (flush_cnt),
    .o_timeout     (timeout),
    .o_state       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [31:0] id, input logic [31:0] ex,
                              input logic wr, input logic [1:0] wb, input logic pc,
                              input logic mr, input logic rdy, input logic [5:0] c,
                              input logic [3:0] s, input logic [3:0] f, input logic to,
                              input hz_state_e st);
    vec_t v;
    v.rst = r; v.id = id; v.ex = ex; v.wren = wr; v.wb = wb; v.pc_sel = pc;
    v.mem_req = mr; v.ready = rdy; v.exp_ctrl = c; v.exp_stall = s;
    v.exp_flush = f; v.exp_to = to; v.exp_state = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    rst = v.rst; instr_id = v.id; instr_ex = v.ex; rd_wren_ex = v.wren;
    wb_sel_ex = v.wb; pc_sel_ex = v.pc_sel; mem_req_mem = v.mem_req; lsu_ready = v.ready;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    check($sformatf("ctrl[%0d]", idx), 32'(ctrl), 32'(v.exp_ctrl));
    @(posedge clk);
    #1;
    check($sformatf("stall_cnt[%0d]", idx), 32'(stall_cnt), 32'(v.exp_stall));
    check($sformatf("flush_cnt[%0d]", idx), 32'(flush_cnt), 32'(v.exp_flush));
    check($sformatf("timeout[%0d]", idx), 32'(timeout), 32'(v.exp_to));
    check($sformatf("state[%0d]", idx), 32'(state), 32'(v.exp_state));
  endtask

  initial begin
    vec_t idle, frz, lu, rd;
    rst = 1'b1; instr_id = I_NOP; instr_ex = I_NOP; rd_wren_ex = 1'b0;
    wb_sel_ex = 2'b00; pc_sel_ex = 1'b0; mem_req_mem = 1'b0; lsu_ready = 1'b0;

    vecs[0]  = mk(1, I_NOP,  I_NOP, 0, 2'b00, 0, 0, 0, C_RST,   0, 0, 0, RUN);
    vecs[1]  = mk(0, I_NOP,  I_NOP, 0, 2'b00, 0, 0, 0, C_IDLE,  0, 0, 0, RUN);
    vecs[2]  = mk(0, I_ADD,  I_LW5, 1, 2'b01, 0, 0, 0, C_LU,    1, 0, 0, RUN);
    vecs[3]  = mk(0, I_NOP,  I_NOP, 0, 2'b00, 0, 0, 0, C_IDLE,  1, 0, 0, RUN);
    vecs[4]  = mk(0, I_ADD,  I_LW0, 1, 2'b01, 0, 0, 0, C_IDLE,  1, 0, 0, RUN);
    vecs[5]  = mk(0, I_Z,    I_LW0, 1, 2'b01, 0, 0, 0, C_IDLE,  1, 0, 0, RUN);
    vecs[6]  = mk(0, I_ADD2, I_LW5, 1, 2'b01, 0, 0, 0, C_LU,    2, 0, 0, RUN);
    vecs[7]  = mk(0, I_ADD,  I_LW5, 1, 2'b00, 0, 0, 0, C_IDLE,  2, 0, 0, RUN);
    vecs[8]  = mk(0, I_ADD,  I_LW5, 0, 2'b01, 0, 0, 0, C_IDLE,  2, 0, 0, RUN);
    vecs[9]  = mk(0, I_ADD,  I_LW5, 1, 2'b10, 0, 0, 0, C_IDLE,  2, 0, 0, RUN);
    vecs[10] = mk(0, I_ADD,  I_LW5, 1, 2'b01, 1, 0, 0, C_REDIR, 2, 1, 0, RUN);
    vecs[11] = mk(0, I_NOP,  I_NOP, 0, 2'b00, 1, 0, 0, C_REDIR, 2, 2, 0, RUN);
    vecs[12] = mk(0, I_ADD,  I_LW5, 1, 2'b01, 1, 1, 0, C_FRZ,   3, 2, 0, MEM_WAIT);
    vecs[13] = mk(0, I_ADD,  I_LW5, 1, 2'b01, 1, 1, 0, C_FRZ,   4, 2, 0, MEM_WAIT);
    vecs[14] = mk(0, I_ADD,  I_LW5, 1, 2'b01, 1, 1, 0, C_FRZ,   5, 2, 0, MEM_WAIT);
    vecs[15] = mk(0, I_ADD,  I_LW5, 1, 2'b01, 1, 1, 1, C_REDIR, 5, 3, 0, RUN);
    vecs[16] = mk(0, I_NOP,  I_NOP, 0, 2'b00, 0, 1, 1, C_IDLE,  5, 3, 0, RUN);
    vecs[17] = mk(0, I_NOP,  I_NOP, 0, 2'b00, 0, 1, 0, C_FRZ,   6, 3, 0, MEM_WAIT);
    vecs[18] = mk(0, I_ADD,  I_LW5, 1, 2'b01, 0, 0, 0, C_LU,    7, 3, 0, RUN);
    vecs[19] = mk(0, I_NOP,  I_NOP, 0, 2'b00, 0, 0, 0, C_IDLE,  7, 3, 0, RUN);
    vecs[20] = mk(1, I_ADD,  I_LW5, 1, 2'b01, 1, 1, 0, C_RST,   0, 0, 0, RUN);

    idle = mk(0, I_NOP, I_NOP, 0, 2'b00, 0, 0, 0, C_IDLE, 0, 0, 0, RUN);
    frz  = mk(0, I_NOP, I_NOP, 0, 2'b00, 0, 1, 0, C_FRZ,  0, 0, 0, MEM_WAIT);
    lu   = mk(0, I_ADD, I_LW5, 1, 2'b01, 0, 0, 0, C_LU,   0, 0, 0, RUN);
    rd   = mk(0, I_NOP, I_NOP, 0, 2'b00, 1, 0, 0, C_REDIR, 0, 0, 0, RUN);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) apply_vec(vecs[i], i);

    // wait counter clears when the freeze breaks
    @(negedge clk); drive(idle);
    repeat (3) begin
      @(negedge clk); drive(frz);
      @(posedge clk); #1;
      check("to_short_run", 32'(timeout), 32'd0);
    end
    @(negedge clk); idle.mem_req = 1'b1; idle.ready = 1'b1; drive(idle);
    idle.mem_req = 1'b0; idle.ready = 1'b0;
    @(posedge clk); #1;
    check("release_state", 32'(state), 32'(RUN));

    // six-cycle freeze: timeout sets after the fourth and does not release the freeze
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive(frz); #1;
      check($sformatf("to_freeze_ctrl[%0d]", i), 32'(ctrl), 32'(C_FRZ));
      @(posedge clk); #1;
      check($sformatf("to_flag[%0d]", i), 32'(timeout), (i >= 3) ? 32'd1 : 32'd0);
      check($sformatf("to_state[%0d]", i), 32'(state), 32'(MEM_WAIT));
    end
    @(negedge clk); drive(idle);
    @(posedge clk); #1;
    check("to_sticky", 32'(timeout), 32'd1);
    check("to_exit_state", 32'(state), 32'(RUN));

    // reset asserted mid-wait acts before the next edge
    @(negedge clk); drive(frz);
    @(posedge clk); #1;
    check("mid_wait_state", 32'(state), 32'(MEM_WAIT));
    @(negedge clk); frz.rst = 1'b1; drive(frz); frz.rst = 1'b0; #1;
    check("rst_ctrl", 32'(ctrl), 32'(C_RST));
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_flush", 32'(flush_cnt), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_state", 32'(state), 32'(RUN));
    @(negedge clk); drive(idle); #1;
    check("post_rst_ctrl", 32'(ctrl), 32'(C_IDLE));
    @(posedge clk); #1;
    check("post_rst_timeout", 32'(timeout), 32'd0);

    // saturation of both 4-bit counters
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(lu); #1;
      check($sformatf("sat_lu_ctrl[%0d]", i), 32'(ctrl), 32'(C_LU));
      @(posedge clk); #1;
      check($sformatf("sat_stall[%0d]", i), 32'(stall_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(rd);
      @(posedge clk); #1;
      check($sformatf("sat_flush[%0d]", i), 32'(flush_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    check("sat_stall_hold", 32'(stall_cnt), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
